// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// Shared definitions for the MEM-stage data-memory access unit:
// funct3 encodings, FSM states and request-formatting helpers.
package mem_access_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f3_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    logic bad;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd) begin
      bad = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    end else begin
      bad = !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
    end
    return bad;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = |lane;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// Combinational load aligner: selects the addressed byte/halfword of a raw
// read word and sign- or zero-extends it; shared with writeback forwarding.
module mem_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// MEM-stage data-memory access unit: issues byte-enabled req/ack accesses,
// stalls the pipeline while outstanding and produces the MEM/WB load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic            ex_mem_MemRead,
  input  logic            ex_mem_MemWrite,
  input  logic [2:0]      ex_mem_funct3,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_write_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] mem_wb_read_data_in,
  output logic            stall,
  output logic            access_error
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rdata_q;
  logic             err_q;

  logic [1:0]      lane;
  logic            start;
  logic            bad_access;
  logic            issue;
  logic            in_wait;
  logic [XLEN-1:0] load_result;

  assign lane       = ex_mem_alu_result[1:0];
  assign start      = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite) & (state_q == ST_IDLE);
  assign bad_access = f3_illegal(ex_mem_MemRead, ex_mem_MemWrite, ex_mem_funct3)
                    | is_misaligned(ex_mem_funct3, lane);
  assign issue      = start & ~bad_access;
  assign in_wait    = (state_q == ST_WAIT);

  // Reset gates the strobe so an abandoned request vanishes within the cycle.
  assign dmem_req   = ~reset & (issue | in_wait);
  assign stall      = dmem_req;
  assign dmem_we    = ex_mem_MemWrite;
  assign dmem_addr  = {ex_mem_alu_result[XLEN-1:2], 2'b00};
  assign dmem_be    = ex_mem_MemWrite ? store_be(ex_mem_funct3, lane) : 4'b1111;

  always_comb begin
    case (ex_mem_funct3[1:0])
      2'b00:   dmem_wdata = {(XLEN/8){ex_mem_write_data[7:0]}};
      2'b01:   dmem_wdata = {(XLEN/16){ex_mem_write_data[15:0]}};
      default: dmem_wdata = ex_mem_write_data;
    endcase
  end

  mem_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i  (dmem_rdata),
    .lane_i   (lane),
    .funct3_i (ex_mem_funct3),
    .result_o (load_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            if (bad_access) begin
              err_q <= 1'b1;
            end else if (dmem_ack) begin
              state_q <= ST_DONE;
              if (ex_mem_MemRead) rdata_q <= load_result;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state_q <= ST_DONE;
            if (ex_mem_MemRead) rdata_q <= load_result;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // One idle cycle lets the pipeline advance before any new start.
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_wb_read_data_in = rdata_q;
  assign access_error        = err_q;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Self-checking bench for mem_access_unit: table-driven accesses with a
// result scoreboard, plus hand-written valid-drop and reset-in-WAIT sequences.
module tb_mem_access_unit;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            ex_mem_valid, ex_mem_MemRead, ex_mem_MemWrite;
  logic [2:0]      ex_mem_funct3;
  logic [XLEN-1:0] ex_mem_alu_result, ex_mem_write_data;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata, mem_wb_read_data_in;
  logic [3:0]      dmem_be;
  logic            stall, access_error;

  always #5 clock = ~clock;

  mem_access_unit #(
    .XLEN(XLEN),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .ex_mem_valid(ex_mem_valid), .ex_mem_MemRead(ex_mem_MemRead),
    .ex_mem_MemWrite(ex_mem_MemWrite), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_write_data(ex_mem_write_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_wb_read_data_in(mem_wb_read_data_in),
    .stall(stall), .access_error(access_error)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;     // cycle index (0 = request cycle) carrying ack; -1 = never
    logic [3:0]  be;
    logic [31:0] dwdata;
    logic        upd;     // access writes a new load result
    logic [31:0] res;
    int          stalls;  // expected stall cycles; 0 = rejected access
    logic        err;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] sb_q [$];
  logic [31:0] model;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, actual=%h", nm, mem_wb_read_data_in);
    end else begin
      chk(nm, mem_wb_read_data_in, sb_q.pop_front());
    end
  endtask

  task automatic drive_idle();
    ex_mem_valid = 1'b0; ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0;
    ex_mem_funct3 = 3'd0; ex_mem_alu_result = '0; ex_mem_write_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int  c      = 0;
    int  stl    = 0;
    int  reqs   = 0;
    bit  done   = 1'b0;
    logic [31:0] aligned;
    @(posedge clock); #1;
    ex_mem_valid = 1'b1; ex_mem_MemRead = v.rd; ex_mem_MemWrite = v.wr;
    ex_mem_funct3 = v.f3; ex_mem_alu_result = v.addr; ex_mem_write_data = v.wdata;
    dmem_rdata = v.rdata;
    if (v.upd) model = v.res;
    sb_q.push_back(model);
    aligned = {v.addr[31:2], 2'b00};
    while (!done && c < 64) begin
      dmem_ack = (c == v.dly);
      @(negedge clock);
      if (stall) begin
        stl++;
        if (dmem_req) reqs++;
        if (c == 0) begin
          chk({v.name, "_be"}, {28'd0, dmem_be}, {28'd0, v.be});
          chk({v.name, "_addr"}, dmem_addr, aligned);
          chk({v.name, "_we"}, {31'd0, dmem_we}, {31'd0, v.wr});
          if (v.wr) chk({v.name, "_wdata"}, dmem_wdata, v.dwdata);
        end
        c++;
        @(posedge clock); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s_bound: stall still high after %0d cycles", v.name, c);
    end
    dmem_ack = 1'b0;
    chk({v.name, "_stalls"}, stl, v.stalls);
    chk({v.name, "_reqs"}, reqs, v.stalls);
    chk({v.name, "_req_low"}, {31'd0, dmem_req}, 32'd0);
    if (v.stalls > 0) begin
      chk({v.name, "_err"}, {31'd0, access_error}, {31'd0, v.err});
      pop_chk({v.name, "_result"});
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      chk({v.name, "_err_clr"}, {31'd0, access_error}, 32'd0);
    end else begin
      chk({v.name, "_err_early"}, {31'd0, access_error}, 32'd0);
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      chk({v.name, "_err"}, {31'd0, access_error}, {31'd0, v.err});
      chk({v.name, "_stall_low"}, {31'd0, stall}, 32'd0);
      pop_chk({v.name, "_result"});
      @(posedge clock); #1;
      @(negedge clock);
      chk({v.name, "_err_clr"}, {31'd0, access_error}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    //          name        rd wr f3  addr     wdata         rdata         dly be     dwdata        upd res           stl err
    tbl[0]  = '{"lw_ack3",   1, 0, 2, 'h100, 'h0,          'hDEADBEEF,    3, 4'hF, 'h0,          1, 'hDEADBEEF,   4, 0};
    tbl[1]  = '{"lb_sext",   1, 0, 0, 'h103, 'h0,          'h80FF0000,    0, 4'hF, 'h0,          1, 'hFFFFFF80,   1, 0};
    tbl[2]  = '{"lbu_zext",  1, 0, 4, 'h103, 'h0,          'h80FF0000,    0, 4'hF, 'h0,          1, 'h00000080,   1, 0};
    tbl[3]  = '{"sh_hi",     0, 1, 1, 'h202, 'h1234ABCD,   'h0,           1, 4'hC, 'hABCDABCD,   0, 'h0,          2, 0};
    tbl[4]  = '{"lw_misal",  1, 0, 2, 'h101, 'h0,          'h0,          -1, 4'hF, 'h0,          0, 'h0,          0, 1};
    tbl[5]  = '{"lw_tmo",    1, 0, 2, 'h104, 'h0,          'h5555AAAA,   -1, 4'hF, 'h0,          1, 'h00000000,   5, 1};
    tbl[6]  = '{"lh_sext",   1, 0, 1, 'h102, 'h0,          'h80011234,    0, 4'hF, 'h0,          1, 'hFFFF8001,   1, 0};
    tbl[7]  = '{"lhu_zext",  1, 0, 5, 'h100, 'h0,          'h8001F234,    2, 4'hF, 'h0,          1, 'h0000F234,   3, 0};
    tbl[8]  = '{"sb_l1",     0, 1, 0, 'h001, 'h000000A5,   'h0,           0, 4'h2, 'hA5A5A5A5,   0, 'h0,          1, 0};
    tbl[9]  = '{"sw",        0, 1, 2, 'h204, 'hCAFEF00D,   'h0,           1, 4'hF, 'hCAFEF00D,   0, 'h0,          2, 0};
    tbl[10] = '{"ld_f3_3",   1, 0, 3, 'h000, 'h0,          'h0,          -1, 4'hF, 'h0,          0, 'h0,          0, 1};
    tbl[11] = '{"rd_and_wr", 1, 1, 2, 'h000, 'h0,          'h0,          -1, 4'hF, 'h0,          0, 'h0,          0, 1};
    tbl[12] = '{"st_f3_4",   0, 1, 4, 'h000, 'h0,          'h0,          -1, 4'hF, 'h0,          0, 'h0,          0, 1};
    tbl[13] = '{"sh_misal",  0, 1, 1, 'h201, 'h0,          'h0,          -1, 4'hF, 'h0,          0, 'h0,          0, 1};
    tbl[14] = '{"sh_lo",     0, 1, 1, 'h200, 'h0000BEEF,   'h0,           0, 4'h3, 'hBEEFBEEF,   0, 'h0,          1, 0};
    tbl[15] = '{"lb_l0",     1, 0, 0, 'h300, 'h0,          'h1234567F,    0, 4'hF, 'h0,          1, 'h0000007F,   1, 0};

    model = '0;
    drive_idle();
    reset = 1'b1;
    #1;
    chk("reset_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_err", {31'd0, access_error}, 32'd0);
    chk("reset_result", mem_wb_read_data_in, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Dropping valid while WAITing must not cancel the access.
    @(posedge clock); #1;
    ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b1; ex_mem_funct3 = 3'd2;
    ex_mem_alu_result = 32'h108; dmem_rdata = 32'h11223344;
    model = 32'h11223344;
    sb_q.push_back(model);
    @(negedge clock); chk("vdrop_req_c0", {31'd0, dmem_req}, 32'd1);
    @(posedge clock); #1 ex_mem_valid = 1'b0;
    @(negedge clock); chk("vdrop_req_c1", {31'd0, dmem_req}, 32'd1);
    @(posedge clock); #1 dmem_ack = 1'b1;
    @(negedge clock); chk("vdrop_req_c2", {31'd0, stall}, 32'd1);
    @(posedge clock); #1 dmem_ack = 1'b0;
    @(negedge clock);
    chk("vdrop_done_stall", {31'd0, stall}, 32'd0);
    chk("vdrop_done_err", {31'd0, access_error}, 32'd0);
    pop_chk("vdrop_result");
    @(posedge clock); #1 drive_idle();

    // Reset in the 2nd WAIT cycle abandons the request; a late ack is ignored.
    @(posedge clock); #1;
    ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b1; ex_mem_funct3 = 3'd2;
    ex_mem_alu_result = 32'h10C; dmem_rdata = 32'h99999999;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock); chk("rst_wait2_req", {31'd0, dmem_req}, 32'd1);
    #1 reset = 1'b1; ex_mem_valid = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall_drop", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, access_error}, 32'd0);
    chk("rst_result_zero", mem_wb_read_data_in, 32'd0);
    model = '0;
    @(posedge clock); #1 reset = 1'b0; dmem_ack = 1'b1;
    @(negedge clock);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1 dmem_ack = 1'b0;
    sb_q.push_back(model);
    @(negedge clock);
    pop_chk("late_ack_result");
    chk("late_ack_err", {31'd0, access_error}, 32'd0);

    run_vec(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access unit for the MEM stage.
- It is the producer that feeds the MEM/WB pipeline register:
  - generates the aligned, extended load data written into mem_wb_read_data_in;
  - drives that register's enable low (via stall) while a memory access is outstanding.
- It issues byte-enabled load/store requests on a req/ack data-memory port and waits for completion.
- It flags misaligned, illegal and timed-out accesses.

Parameters:
- XLEN, 32, data/address width; value taken from the shared RISCV.h header.
- ACK_TIMEOUT, 255, maximum number of WAIT cycles without dmem_ack before the access is aborted.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ex_mem_valid  in  1  MEM-stage instruction is valid
- ex_mem_MemRead  in  1  instruction is a load
- ex_mem_MemWrite  in  1  instruction is a store
- ex_mem_funct3  in  3  width/sign selector (LB/LH/LW/LBU/LHU, SB/SH/SW)
- ex_mem_alu_result  in  XLEN  effective byte address
- ex_mem_write_data  in  XLEN  store data (rs2 value)
- dmem_req  out  1  request strobe
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid on reads
- dmem_rdata  in  XLEN  raw read word
- mem_wb_read_data_in  out  XLEN  registered, aligned and extended load result
- stall  out  1  hold IF..MEM and the MEM/WB enable low
- access_error  out  1  one-cycle pulse: misaligned, illegal or timeout

Behaviour:
- Asynchronous reset puts the block in a known idle state:
  - state = IDLE, timeout counter = 0;
  - mem_wb_read_data_in = 0, access_error = 0;
  - dmem_req drops immediately, so stall = 0.
- Definitions:
  - start = ex_mem_valid & (MemRead | MemWrite) & state == IDLE.
  - illegal = MemRead & MemWrite, or a funct3 not defined for the operation (loads: 3,6,7; stores: 3..7).
  - misaligned = halfword with addr[0] = 1, or word with addr[1:0] != 0.
- State machine:
  - IDLE:
    - start & !illegal & !misaligned: dmem_req = 1 and stall = 1 combinationally.
      - dmem_ack in the same cycle -> DONE.
      - otherwise -> WAIT.
    - start with an illegal or misaligned access: no request, stall = 0, access_error = 1 on the next cycle; mem_wb_read_data_in unchanged; stay in IDLE.
  - WAIT:
    - dmem_req = 1, stall = 1; counter increments each cycle.
    - dmem_ack -> DONE.
    - counter == ACK_TIMEOUT-1 without ack -> DONE with access_error pulsed and read data forced to 0.
  - DONE:
    - stall = 0, dmem_req = 0, counter cleared; -> IDLE.
    - The pipeline advances at the end of this cycle.
    - DONE suppresses re-issue of the same instruction.
- Latency and stalls:
  - Minimum stall is 1 cycle, with a zero-wait ack.
  - Loaded data is registered on the ack edge and stable from DONE onward.
- Request-side outputs:
  - dmem_addr, dmem_be, dmem_wdata and dmem_we are combinational from the held ex_mem_* inputs.
  - They are only meaningful while dmem_req = 1.
- Store formatting, lane = addr[1:0]:
  - SB: be = 4'b0001 << lane, wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011 or 4'b1100, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
- Loads:
  - dmem_be = 4'b1111.
  - Result: lane-selected byte/halfword, sign-extended for LB/LH, zero-extended for LBU/LHU; LW passes the word through.
- Stores leave mem_wb_read_data_in unchanged.
- dmem_ack is ignored while dmem_req = 0.
- An ex_mem_valid drop during WAIT does not cancel the request; the access completes.
- Reset in WAIT:
  - the request is abandoned immediately;
  - a subsequent late ack is ignored.

Decomposition:
- funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW), state encodings and the XLEN default go in the shared RISCV.h header.
- One combinational sub-module, mem_load_align (rdata, lane, funct3 -> extended result), reused by the writeback forwarding path.

Test Plan:
1. LW at address 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
   - stall high for 4 cycles, dmem_be = 4'b1111;
   - mem_wb_read_data_in = 0xDEADBEEF in DONE.
2. LB at address 0x103 with rdata 0x80FF_0000, zero-wait ack:
   - result = 0xFFFFFF80, stall exactly 1 cycle.
   - The same access as LBU gives 0x00000080.
3. SH at address 0x202 with data 0x1234ABCD:
   - dmem_be = 4'b1100, dmem_wdata = 0xABCDABCD, dmem_we = 1;
   - read data unchanged.
4. LW at address 0x101:
   - no dmem_req, stall = 0;
   - access_error pulses for 1 cycle; state stays IDLE.
5. Load with no ack for ACK_TIMEOUT (test with 4):
   - abort after 4 WAIT cycles, access_error pulse, result = 0, then IDLE.
6. Reset asserted in the 2nd WAIT cycle, then ack arrives:
   - dmem_req and stall drop immediately, outputs return to 0;
   - the late ack is ignored.
